// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler: scan sequencer and round-robin write arbiter for an
// 8-digit multiplexed seven-segment display. Holds the BCD digit buffer,
// drives active-low anodes and the lit digit's BCD code to the cathode
// decoder.
// Optional feature: define SSD_BLANK_EN to insert BLANK_CYC cycles of
// all-anodes-off between digits (anti-ghosting).
//
// state | meaning
// IDLE  | display dark, index and dwell counter cleared
// SCAN  | digit digit_idx lit for TICK_DIV cycles
// BLANK | all anodes off for BLANK_CYC cycles (SSD_BLANK_EN only)
module ssd_scan_scheduler #(
  parameter int TICK_DIV  = 12500,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_req_a,
  input  logic [2:0] wr_idx_a,
  input  logic [3:0] wr_data_a,
  input  logic       wr_req_b,
  input  logic [2:0] wr_idx_b,
  input  logic [3:0] wr_data_b,
  output logic       wr_gnt_a,
  output logic       wr_gnt_b,
  output logic [7:0] anodes,
  output logic [3:0] bcd_out,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TICK_LD = CNT_W'(TICK_DIV - 1);
`ifdef SSD_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
`ifdef SSD_BLANK_EN
    , BLANK = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       anodes_q, anodes_d;
  logic             frame_q, frame_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       buf_q [8];

  // Round-robin grant: ptr_q = 0 favours A, 1 favours B on contention.
  always_comb begin
    wr_gnt_a = wr_req_a & (~wr_req_b | ~ptr_q);
    wr_gnt_b = wr_req_b & (~wr_req_a | ptr_q);
    ptr_d    = ptr_q;
    if (wr_gnt_a)      ptr_d = 1'b1;
    else if (wr_gnt_b) ptr_d = 1'b0;
  end

  // Digit buffer and arbiter pointer; writes land in every scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= 4'd0;
    end else begin
      ptr_q <= ptr_d;
      if (wr_gnt_a)      buf_q[wr_idx_a] <= wr_data_a;
      else if (wr_gnt_b) buf_q[wr_idx_b] <= wr_data_b;
    end
  end

  // Scan next-state: down-counter dwell, index wrap flags frame_done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          cnt_d   = TICK_LD;
          idx_d   = 3'd0;
        end
        SCAN: begin
          if (cnt_q == '0) begin
`ifdef SSD_BLANK_EN
            state_d = BLANK;
            cnt_d   = BLANK_LD;
`else
            cnt_d   = TICK_LD;
            idx_d   = idx_q + 3'd1;
            frame_d = (idx_q == 3'd7);
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef SSD_BLANK_EN
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SCAN;
            cnt_d   = TICK_LD;
            idx_d   = idx_q + 3'd1;
            frame_d = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
    anodes_d = (state_d == SCAN) ? ~(8'h01 << idx_d) : 8'hFF;
  end

  // Scan state register; anodes and frame_done registered from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      anodes_q <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      frame_q  <= frame_d;
    end
  end

  assign anodes     = anodes_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_q;
  assign bcd_out    = buf_q[idx_q];

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler with TICK_DIV = 4, BLANK_CYC = 2.
// Expected values are queued when stimulus is applied and popped after the
// clock edge that should produce them.
module tb_ssd_scan_scheduler;

  localparam int TICK = 4;
  localparam int BLK  = 2;
`ifdef SSD_BLANK_EN
  localparam int BL = BLK;
`else
  localparam int BL = 0;
`endif
  localparam int P = TICK + BL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_req_a = 1'b0, wr_req_b = 1'b0;
  logic [2:0] wr_idx_a = 3'd0, wr_idx_b = 3'd0;
  logic [3:0] wr_data_a = 4'd0, wr_data_b = 4'd0;
  logic       wr_gnt_a, wr_gnt_b;
  logic [7:0] anodes;
  logic [3:0] bcd_out;
  logic [2:0] digit_idx;
  logic       frame_done;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q [$];

  ssd_scan_scheduler #(.TICK_DIV(TICK), .BLANK_CYC(BLK)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wr_req_a(wr_req_a), .wr_idx_a(wr_idx_a), .wr_data_a(wr_data_a),
    .wr_req_b(wr_req_b), .wr_idx_b(wr_idx_b), .wr_data_b(wr_data_b),
    .wr_gnt_a(wr_gnt_a), .wr_gnt_b(wr_gnt_b),
    .anodes(anodes), .bcd_out(bcd_out), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    wr_req_a = 1'b0;
    wr_req_b = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Independent frame model: t counts edges since enable was first sampled.
  function automatic logic [11:0] scan_model(input int t);
    int d;
    int ph;
    logic [7:0] an;
    logic fd;
    d  = (t / P) % 8;
    ph = t % P;
    an = (ph < TICK) ? ~(8'h01 << d) : 8'hFF;
    fd = (t > 0) && ((t % (8 * P)) == 0);
    return {an, fd, 3'(d)};
  endfunction

  task automatic run_scan(input int n);
    logic [31:0] e;
    for (int t = 0; t < n; t++) begin
      exp_q.push_back({20'd0, scan_model(t)});
      tick();
      e = exp_q.pop_front();
      check_val($sformatf("scan t=%0d", t), {20'd0, anodes, frame_done, digit_idx}, e);
    end
  endtask

  task automatic write_digit(input bit use_b, input logic [2:0] idx, input logic [3:0] val);
    bit got;
    got = 1'b0;
    if (use_b) begin
      wr_req_b = 1'b1; wr_idx_b = idx; wr_data_b = val;
    end else begin
      wr_req_a = 1'b1; wr_idx_a = idx; wr_data_a = val;
    end
    for (int k = 0; k < 4 && !got; k++) begin
      #1;
      got = use_b ? wr_gnt_b : wr_gnt_a;
      tick();
    end
    check_val("wr_gnt", 32'(got), 32'd1);
    wr_req_a = 1'b0;
    wr_req_b = 1'b0;
  endtask

  task automatic check_both_req(input string tag, input logic [1:0] exp);
    wr_req_a = 1'b1;
    wr_req_b = 1'b1;
    #1;
    check_val(tag, {30'd0, wr_gnt_a, wr_gnt_b}, {30'd0, exp});
    wr_req_a = 1'b0;
    wr_req_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    do_reset();
    // reset state
    check_val("rst_anodes", {24'd0, anodes}, 32'hFF);
    check_val("rst_idx", {29'd0, digit_idx}, 32'd0);
    check_val("rst_frame", {31'd0, frame_done}, 32'd0);
    check_val("rst_bcd", {28'd0, bcd_out}, 32'd0);
    check_both_req("rst_ptr", 2'b10);
    wr_req_b = 1'b1;
    #1;
    check_val("gnt_b_only", {30'd0, wr_gnt_a, wr_gnt_b}, 32'd1);
    wr_req_b = 1'b0;
    #1;
    check_val("gnt_none", {30'd0, wr_gnt_a, wr_gnt_b}, 32'd0);

    // two full frames from enable
    enable = 1'b1;
    run_scan(16 * P + 2);

    // drop enable inside digit 5, then re-raise
    do_reset();
    enable = 1'b1;
    run_scan(5 * P + 2);
    enable = 1'b0;
    tick();
    check_val("drop_anodes", {24'd0, anodes}, 32'hFF);
    check_val("drop_idx", {29'd0, digit_idx}, 32'd0);
    check_val("drop_frame", {31'd0, frame_done}, 32'd0);
    enable = 1'b1;
    run_scan(P + 1);

    // write digit 0 while it is lit
    do_reset();
    enable = 1'b1;
    tick();
    check_val("lit0_anodes", {24'd0, anodes}, 32'hFE);
    check_val("lit0_bcd_pre", {28'd0, bcd_out}, 32'd0);
    wr_req_a = 1'b1; wr_idx_a = 3'd0; wr_data_a = 4'd7;
    #1;
    check_val("lit0_gnt", {31'd0, wr_gnt_a}, 32'd1);
    exp_q.push_back(32'd7);
    tick();
    wr_req_a = 1'b0;
    check_val("lit0_bcd_post", {28'd0, bcd_out}, exp_q.pop_front());
    check_val("lit0_anodes_post", {24'd0, anodes}, 32'hFE);

    // contention on index 3: grants alternate A, B, A
    do_reset();
    wr_req_a = 1'b1; wr_idx_a = 3'd3; wr_data_a = 4'd5;
    wr_req_b = 1'b1; wr_idx_b = 3'd3; wr_data_b = 4'd9;
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("arb%0d", k), {30'd0, wr_gnt_a, wr_gnt_b}, exp_q.pop_front());
      tick();
    end
    wr_req_a = 1'b0;
    wr_req_b = 1'b0;
    check_both_req("ptr_after_aba", 2'b01);
    enable = 1'b1;
    run_scan(3 * P + 1);
    check_val("d3_bcd", {28'd0, bcd_out}, 32'd5);

    // fill buffer with 8, reset mid-BLANK (mid-dwell without blanking)
    do_reset();
    for (int i = 0; i < 9; i++) write_digit(bit'(i % 2), 3'(i % 8), 4'd8);
    enable = 1'b1;
    run_scan(2 * P + TICK + 1);
    check_val("fill_bcd", {28'd0, bcd_out}, 32'd8);
    do_reset();
    check_val("rst2_anodes", {24'd0, anodes}, 32'hFF);
    check_val("rst2_idx", {29'd0, digit_idx}, 32'd0);
    check_val("rst2_frame", {31'd0, frame_done}, 32'd0);
    check_val("rst2_bcd", {28'd0, bcd_out}, 32'd0);
    check_both_req("rst2_ptr", 2'b10);
    enable = 1'b1;
    for (int t = 0; t < 8 * P; t++) begin
      tick();
      if (t % P == 0) check_val($sformatf("clr_bcd d%0d", t / P), {28'd0, bcd_out}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ssd_scan_scheduler.md
# ssd_scan_scheduler

Sequencer and write arbiter for the 8-digit multiplexed seven-segment display on the 100 MHz board clock. It holds an 8-entry BCD digit buffer and accepts digit writes from two independent requesters through a round-robin arbiter. It scans the digits with programmable dwell and optional inter-digit blanking, driving active-low anodes and the current digit's BCD code into the existing BCD_SSD_driver for cathode decode.

## Interface
- TICK_DIV, 12500: clk cycles each digit is lit (12500 gives 8 kHz digit rate, 1 kHz frame); legal range ≥ 2.
- BLANK_CYC, 16: clk cycles all anodes are off between digits (only with SSD_BLANK_EN); legal range ≥ 1.
- clk  input  1  board clock, 100 MHz.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- enable  input  1  1 = scan runs; 0 = display dark.
- wr_req_a / wr_req_b  input  1  write request, held until granted.
- wr_idx_a / wr_idx_b  input  3  target digit index 0..7.
- wr_data_a / wr_data_b  input  4  BCD value to store.
- wr_gnt_a / wr_gnt_b  output  1  combinational grant; the write commits on the clk edge where req & gnt.
- anodes  output  8  registered, active-low, one-hot-low while lit.
- bcd_out  output  4  buffer[digit_idx], combinational from registered state.
- digit_idx  output  3  registered index of the digit being scanned.
- frame_done  output  1  registered one-cycle pulse at each 7→0 wrap.

## Operation
- Digit buffer: 8 × 4-bit registers, all 0 after reset.
- Arbiter:
  - At most one write per cycle.
  - If only one requester is active, it is granted.
  - If both are active, the one selected by the priority pointer wins.
  - After any grant, the pointer moves to the other requester.
  - The pointer selects A after reset.
  - The grant for a request without wr_req is 0.
- Written value appears on bcd_out the cycle after the commit edge if its index equals digit_idx.
- Scan FSM states: IDLE, SCAN, BLANK (BLANK exists only with SSD_BLANK_EN).
  - IDLE: anodes = 8'hFF, digit_idx = 0, dwell counter = 0. With enable = 1 at an edge → SCAN with anodes = 8'hFE.
  - SCAN: anodes = ~(1 << digit_idx), held for exactly TICK_DIV cycles. Then → BLANK, or → SCAN of the next digit when blanking is compiled out.
  - BLANK: anodes = 8'hFF for exactly BLANK_CYC cycles. Then → SCAN with digit_idx + 1.
- Index advances modulo 8 (7 → 0).
- frame_done = 1 in the first cycle of SCAN for digit 0 following digit 7. It does not fire on the first entry from IDLE.
- Arbitration and buffer writes operate in every FSM state, including IDLE.

## Timing
- Reset values: anodes 8'hFF, digit_idx 0, frame_done 0, FSM IDLE, counter 0, pointer A, buffer all 0. bcd_out = 0 follows from the buffer.
- Latency: enable rising and sampled at edge N gives anodes = 8'hFE after edge N.
- Enable dropped mid-SCAN or mid-BLANK: IDLE after the next edge, anodes 8'hFF, digit_idx 0. Re-enable restarts at digit 0 with a full dwell.
- Reset mid-operation: all state, including buffer contents, returns to reset values at that edge. Reset overrides enable and writes.
- Simultaneous requests to the same index: only the granted write lands. The loser stays pending and lands on a later cycle, so the last write wins.
- Dwell counter width is $clog2 of the larger of TICK_DIV and BLANK_CYC. No overflow is possible within the legal ranges.
- Frame period: 8·(TICK_DIV+BLANK_CYC) cycles with blanking, 8·TICK_DIV cycles without.

## Configuration
- SSD_BLANK_EN defined: the BLANK state and BLANK_CYC are active, with anodes off between digits to suppress ghosting.
- SSD_BLANK_EN undefined: there is no BLANK state and BLANK_CYC is ignored. SCAN goes directly to the next digit, and anodes change one-hot-low to one-hot-low in a single edge.

## Test plan
- Reset, then enable = 1, with TICK_DIV = 4 and BLANK_CYC = 2 (macro on) → anodes sequence per digit:
  - 8'hFE for 4 cycles, 8'hFF for 2 cycles, 8'hFD for 4 cycles, …, 8'h7F.
  - frame_done is a single pulse when 8'hFE returns after 48 cycles.
- Same bench with the macro off → 8'hFE, 8'hFD, … each exactly 4 cycles, with no 8'hFF cycles and frame_done every 32 cycles.
- Both requesters assert continuously, with A writing idx 3 = 5 and B writing idx 3 = 9 → grants alternate A, B, A. Buffer[3] ends at the value of the last grant, and bcd_out = 5 or 9 while digit 3 is lit, matching the most recent commit.
- Write idx 0 = 7 while digit 0 is lit → bcd_out changes from 0 to 7 one cycle after the commit edge, and anodes are unaffected.
- Drop enable in the middle of digit 5, then re-raise it → anodes = 8'hFF and digit_idx = 0 the next cycle, then 8'hFE for a full TICK_DIV, with no frame_done pulse.
- Assert reset for one cycle mid-BLANK after writing 8 for every digit → all outputs at reset values, buffer reads 0, and arbiter pointer at A.
